ascon_aead_ctrl: RTL and testbench

//  Control FSM for the ASCON-AEAD128 encryption datapath: sequences init (p^a), AD absorb (p^b), PT encrypt (p^b), final (p^a).

---
 rtl/ascon_aead_ctrl_pkg.sv | 34 +++
 rtl/ascon_aead_ctrl_round_counter.sv | 37 +++
 rtl/ascon_aead_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ascon_aead_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_aead_ctrl_pkg.sv
// Shared types and constants for the ASCON-AEAD128 control path.
// Pure declarations; no logic, no latency.
package ascon_aead_ctrl_pkg;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 8;
  localparam logic [3:0] ROUND_LAST = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD_WAIT,
    ST_AD_RUN,
    ST_PT_WAIT,
    ST_PT_RUN,
    ST_FINAL
  } ctrl_state_t;

  localparam logic [1:0] XE_NONE     = 2'b00;
  localparam logic [1:0] XE_KEY      = 2'b01;
  localparam logic [1:0] XE_DSEP     = 2'b10;
  localparam logic [1:0] XE_KEY_DSEP = 2'b11;

  localparam logic [1:0] PHASE_IDLE  = 2'b00;
  localparam logic [1:0] PHASE_AD    = 2'b01;
  localparam logic [1:0] PHASE_PT    = 2'b10;
  localparam logic [1:0] PHASE_FINAL = 2'b11;

  // First round index of a permutation that runs n rounds and ends on round 11.
  function automatic logic [3:0] first_round(input int n);
    return 4'(12 - n);
  endfunction

endpackage

// File: rtl/ascon_aead_ctrl_round_counter.sv
// Permutation round index: loadable, increments, saturates at round 11.
// Load/increment take effect on the next rising edge; never stalls.
module ascon_aead_ctrl_round_counter
  import ascon_aead_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] round_o,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  assign last_o  = (cnt_q == ROUND_LAST);
  assign round_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ascon_aead_ctrl.sv
// ASCON-AEAD128 encrypt sequencer: init, AD absorb, PT encrypt, final; one round per cycle.
// Blocks accepted only while waiting between permutations; without a transfer the state is held.
module ascon_aead_ctrl
  import ascon_aead_ctrl_pkg::*;
#(
  parameter int ROUNDS_A_P = ROUNDS_A,
  parameter int ROUNDS_B_P = ROUNDS_B
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       ad_present_i,
  input  logic       blk_valid_i,
  input  logic       blk_last_i,
  output logic       blk_ready_o,
  output logic [1:0] phase_o,
  output logic       init_o,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       enable_xor_b_o,
  output logic       final_key_o,
  output logic [1:0] enable_xor_e_o,
  output logic       enable_cipher_o,
  output logic       enable_tag_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam logic [3:0] A_FIRST = first_round(ROUNDS_A_P);
  localparam logic [3:0] B_FIRST = first_round(ROUNDS_B_P);

  ctrl_state_t state_q, state_d;
  logic        ad_q, ad_d;
  logic        last_q, last_d;
  logic        cipher_valid_q, tag_valid_q;
  logic        cnt_load, cnt_inc, cnt_last;
  logic [3:0]  cnt_val, cnt_round;

  ascon_aead_ctrl_round_counter u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .inc_i      (cnt_inc),
    .round_o    (cnt_round),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d         = state_q;
    ad_d            = ad_q;
    last_d          = last_q;
    cnt_load        = 1'b0;
    cnt_val         = 4'd0;
    cnt_inc         = 1'b0;
    blk_ready_o     = 1'b0;
    phase_o         = PHASE_IDLE;
    init_o          = 1'b0;
    round_o         = 4'd0;
    enable_o        = 1'b0;
    enable_xor_b_o  = 1'b0;
    final_key_o     = 1'b0;
    enable_xor_e_o  = XE_NONE;
    enable_cipher_o = 1'b0;
    enable_tag_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_INIT;
          ad_d     = ad_present_i;
          cnt_load = 1'b1;
          cnt_val  = A_FIRST;
        end
      end
      ST_INIT: begin
        enable_o = 1'b1;
        round_o  = cnt_round;
        init_o   = (cnt_round == A_FIRST);
        cnt_inc  = 1'b1;
        if (cnt_last) begin
          enable_xor_e_o = ad_q ? XE_KEY : XE_KEY_DSEP;
          state_d        = ad_q ? ST_AD_WAIT : ST_PT_WAIT;
        end
      end
      ST_AD_WAIT: begin
        phase_o     = PHASE_AD;
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          enable_o       = 1'b1;
          enable_xor_b_o = 1'b1;
          round_o        = B_FIRST;
          cnt_load       = 1'b1;
          cnt_val        = B_FIRST + 4'd1;
          last_d         = blk_last_i;
          state_d        = ST_AD_RUN;
        end
      end
      ST_AD_RUN: begin
        phase_o  = PHASE_AD;
        enable_o = 1'b1;
        round_o  = cnt_round;
        cnt_inc  = 1'b1;
        if (cnt_last) begin
          enable_xor_e_o = last_q ? XE_DSEP : XE_NONE;
          state_d        = last_q ? ST_PT_WAIT : ST_AD_WAIT;
        end
      end
      ST_PT_WAIT: begin
        phase_o     = PHASE_PT;
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          enable_o        = 1'b1;
          enable_xor_b_o  = 1'b1;
          enable_cipher_o = 1'b1;
          cnt_load        = 1'b1;
          // The last PT block doubles as round 0 of the finalisation.
          if (blk_last_i) begin
            final_key_o = 1'b1;
            round_o     = A_FIRST;
            cnt_val     = A_FIRST + 4'd1;
            state_d     = ST_FINAL;
          end else begin
            round_o = B_FIRST;
            cnt_val = B_FIRST + 4'd1;
            state_d = ST_PT_RUN;
          end
        end
      end
      ST_PT_RUN: begin
        phase_o  = PHASE_PT;
        enable_o = 1'b1;
        round_o  = cnt_round;
        cnt_inc  = 1'b1;
        if (cnt_last) begin
          state_d = ST_PT_WAIT;
        end
      end
      ST_FINAL: begin
        phase_o  = PHASE_FINAL;
        enable_o = 1'b1;
        round_o  = cnt_round;
        cnt_inc  = 1'b1;
        if (cnt_last) begin
          enable_xor_e_o = XE_KEY;
          enable_tag_o   = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q        <= ST_IDLE;
      ad_q           <= 1'b0;
      last_q         <= 1'b0;
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ad_q           <= ad_d;
      last_q         <= last_d;
      cipher_valid_q <= enable_cipher_o;
      tag_valid_q    <= enable_tag_o;
    end
  end

  assign cipher_valid_o = cipher_valid_q;
  assign tag_valid_o    = tag_valid_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Directed bench for the ASCON-AEAD128 control sequencer.
module tb_ascon_aead_ctrl;

  localparam int NCYC = 64;

  logic       clock_i, resetb_i, start_i, ad_present_i, blk_valid_i, blk_last_i;
  logic       blk_ready_o, init_o, enable_o, enable_xor_b_o, final_key_o;
  logic       enable_cipher_o, enable_tag_o, cipher_valid_o, tag_valid_o, busy_o;
  logic [1:0] phase_o, enable_xor_e_o;
  logic [3:0] round_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] t_round [NCYC];
  logic [1:0] t_xe    [NCYC];
  logic [1:0] t_ph    [NCYC];
  logic       t_en    [NCYC];
  logic       t_rdy   [NCYC];
  logic       t_xb    [NCYC];
  logic       t_fk    [NCYC];
  logic       t_cen   [NCYC];
  logic       t_ten   [NCYC];
  logic       t_init  [NCYC];
  logic       t_busy  [NCYC];
  int         tv_cyc, n_tv, n_dsep;
  int         cv_cyc[$];
  int         xf_cyc[$];

  ascon_aead_ctrl dut (
    .clock_i         (clock_i),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
    .ad_present_i    (ad_present_i),
    .blk_valid_i     (blk_valid_i),
    .blk_last_i      (blk_last_i),
    .blk_ready_o     (blk_ready_o),
    .phase_o         (phase_o),
    .init_o          (init_o),
    .round_o         (round_o),
    .enable_o        (enable_o),
    .enable_xor_b_o  (enable_xor_b_o),
    .final_key_o     (final_key_o),
    .enable_xor_e_o  (enable_xor_e_o),
    .enable_cipher_o (enable_cipher_o),
    .enable_tag_o    (enable_tag_o),
    .cipher_valid_o  (cipher_valid_o),
    .tag_valid_o     (tag_valid_o),
    .busy_o          (busy_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, blk_ready_o, phase_o, init_o, round_o, enable_o, enable_xor_b_o,
            final_key_o, enable_xor_e_o, enable_cipher_o, enable_tag_o,
            cipher_valid_o, tag_valid_o, busy_o};
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Cycle 0 is the cycle carrying start_i. The feeder keeps its next block
  // presented, optionally withholding the first PT block for `stall` ready cycles.
  task automatic run_op(input bit ad, input int n_ad, input int n_pt, input int stall,
                        input int s1, input int s2);
    int k = 0;
    int total = n_ad + n_pt;
    int stall_left = stall;
    tv_cyc = -1; n_tv = 0; n_dsep = 0;
    cv_cyc.delete(); xf_cyc.delete();
    for (int c = 0; c < NCYC; c++) begin
      start_i      = (c == 0) || (c == s1) || (c == s2);
      ad_present_i = ad;
      blk_valid_i  = (k < total) && !(k == n_ad && stall_left > 0);
      blk_last_i   = (k == n_ad - 1) || (k == total - 1);
      #1;
      t_round[c] = round_o;  t_xe[c]  = enable_xor_e_o; t_ph[c]   = phase_o;
      t_en[c]    = enable_o; t_rdy[c] = blk_ready_o;    t_xb[c]   = enable_xor_b_o;
      t_fk[c]    = final_key_o; t_cen[c] = enable_cipher_o; t_ten[c] = enable_tag_o;
      t_init[c]  = init_o;   t_busy[c] = busy_o;
      if (tag_valid_o) begin
        n_tv++;
        if (tv_cyc < 0) tv_cyc = c;
      end
      if (cipher_valid_o) cv_cyc.push_back(c);
      if (enable_xor_e_o == 2'b10) n_dsep++;
      if (blk_valid_i && blk_ready_o) begin
        xf_cyc.push_back(c);
        k++;
      end else if (blk_ready_o && phase_o == 2'b10 && k == n_ad && stall_left > 0) begin
        stall_left--;
      end
      @(posedge clock_i);
      #1;
    end
    start_i = 1'b0;
    blk_valid_i = 1'b0;
  endtask

  initial begin
    resetb_i = 1'b1; start_i = 1'b0; ad_present_i = 1'b0;
    blk_valid_i = 1'b0; blk_last_i = 1'b0;
    tick(); tick();
    resetb_i = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 32'd0);
    tick();

    // Reset in the middle of INIT.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    #1;
    chk("midinit_round5", {28'd0, round_o}, 32'd5);
    chk("midinit_busy", {31'd0, busy_o}, 32'd1);
    resetb_i = 1'b1;
    tick();
    resetb_i = 1'b0;
    #1;
    chk("abort_outs", all_outs(), 32'd0);
    tick();
    chk("abort_idle_outs", all_outs(), 32'd0);

    // No AD, one PT block: also shows start is accepted again after abort.
    run_op(1'b0, 0, 1, 0, -1, -1);
    chk("t2_c0_busy", {31'd0, t_busy[0]}, 32'd0);
    chk("t2_c1_init", {31'd0, t_init[1]}, 32'd1);
    chk("t2_c1_round", {28'd0, t_round[1]}, 32'd0);
    chk("t2_c2_init", {31'd0, t_init[2]}, 32'd0);
    chk("t2_c12_xe", {30'd0, t_xe[12]}, 32'd3);
    chk("t2_c12_round", {28'd0, t_round[12]}, 32'd11);
    chk("t2_c13_ph", {30'd0, t_ph[13]}, 32'd2);
    chk("t2_c13_cen", {31'd0, t_cen[13]}, 32'd1);
    chk("t2_c13_fk", {31'd0, t_fk[13]}, 32'd1);
    chk("t2_c13_xb", {31'd0, t_xb[13]}, 32'd1);
    chk("t2_c13_round", {28'd0, t_round[13]}, 32'd0);
    chk("t2_c14_round", {28'd0, t_round[14]}, 32'd1);
    chk("t2_c14_ph", {30'd0, t_ph[14]}, 32'd3);
    chk("t2_c24_ten", {31'd0, t_ten[24]}, 32'd1);
    chk("t2_c24_xe", {30'd0, t_xe[24]}, 32'd1);
    chk("t2_c24_busy", {31'd0, t_busy[24]}, 32'd1);
    chk("t2_tv_cyc", tv_cyc, 32'd25);
    chk("t2_n_tv", n_tv, 32'd1);
    chk("t2_c25_busy", {31'd0, t_busy[25]}, 32'd0);
    chk("t2_n_cv", cv_cyc.size(), 32'd1);
    if (cv_cyc.size() > 0) chk("t2_cv_cyc", cv_cyc[0], 32'd14);

    // Two AD blocks, one PT block, no stalls.
    run_op(1'b1, 2, 1, 0, -1, -1);
    chk("t3_c12_xe", {30'd0, t_xe[12]}, 32'd1);
    chk("t3_c13_ph", {30'd0, t_ph[13]}, 32'd1);
    chk("t3_c13_round", {28'd0, t_round[13]}, 32'd4);
    chk("t3_c13_xb", {31'd0, t_xb[13]}, 32'd1);
    chk("t3_c13_cen", {31'd0, t_cen[13]}, 32'd0);
    chk("t3_c20_round", {28'd0, t_round[20]}, 32'd11);
    chk("t3_c20_xe", {30'd0, t_xe[20]}, 32'd0);
    chk("t3_c21_round", {28'd0, t_round[21]}, 32'd4);
    chk("t3_c28_xe", {30'd0, t_xe[28]}, 32'd2);
    chk("t3_n_dsep", n_dsep, 32'd1);
    chk("t3_c29_fk", {31'd0, t_fk[29]}, 32'd1);
    chk("t3_c29_ph", {30'd0, t_ph[29]}, 32'd2);
    chk("t3_tv_cyc", tv_cyc, 32'd41);
    chk("t3_n_cv", cv_cyc.size(), 32'd1);
    if (cv_cyc.size() > 0) chk("t3_cv_cyc", cv_cyc[0], 32'd30);

    // PT_WAIT starved for 5 cycles.
    run_op(1'b0, 0, 1, 5, -1, -1);
    for (int c = 13; c < 18; c++) begin
      chk($sformatf("t4_c%0d_en", c), {31'd0, t_en[c]}, 32'd0);
      chk($sformatf("t4_c%0d_rdy", c), {31'd0, t_rdy[c]}, 32'd1);
      chk($sformatf("t4_c%0d_ph", c), {30'd0, t_ph[c]}, 32'd2);
    end
    chk("t4_c18_fk", {31'd0, t_fk[18]}, 32'd1);
    chk("t4_c18_en", {31'd0, t_en[18]}, 32'd1);
    chk("t4_tv_cyc", tv_cyc, 32'd30);

    // Three PT blocks.
    run_op(1'b0, 0, 3, 0, -1, -1);
    chk("t5_n_xf", xf_cyc.size(), 32'd3);
    chk("t5_n_cv", cv_cyc.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < xf_cyc.size()) chk($sformatf("t5_xf%0d", i), xf_cyc[i], 32'(13 + 8 * i));
      if (i < cv_cyc.size()) chk($sformatf("t5_cv%0d", i), cv_cyc[i], 32'(14 + 8 * i));
    end
    chk("t5_c13_round", {28'd0, t_round[13]}, 32'd4);
    chk("t5_c14_round", {28'd0, t_round[14]}, 32'd5);
    chk("t5_c20_round", {28'd0, t_round[20]}, 32'd11);
    chk("t5_c21_round", {28'd0, t_round[21]}, 32'd4);
    chk("t5_c21_fk", {31'd0, t_fk[21]}, 32'd0);
    chk("t5_c29_fk", {31'd0, t_fk[29]}, 32'd1);
    chk("t5_tv_cyc", tv_cyc, 32'd41);

    // Stray start pulses during AD_RUN (cyc 15) and FINAL (cyc 28).
    run_op(1'b1, 1, 1, 0, 15, 28);
    chk("t6_c15_ph", {30'd0, t_ph[15]}, 32'd1);
    chk("t6_c20_xe", {30'd0, t_xe[20]}, 32'd2);
    chk("t6_c28_ph", {30'd0, t_ph[28]}, 32'd3);
    chk("t6_tv_cyc", tv_cyc, 32'd33);
    chk("t6_n_tv", n_tv, 32'd1);
    chk("t6_c40_busy", {31'd0, t_busy[40]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
